// File: rtl/trace_recorder_if.sv
// Bird-motion / scan-pixel inputs and per-bird renderer outputs of one trace_recorder.
// The master side is the driver of positions and scan pixels; the slave side is the recorder.
interface trace_recorder_if #(
    parameter int NUM_TRACES = 8
);
    localparam int CW = $clog2(NUM_TRACES) + 1;

    logic          startOfFrame;
    logic          flying;
    logic          clearTraces;
    logic [10:0]   birdX;
    logic [10:0]   birdY;
    logic [10:0]   pixelX;
    logic [10:0]   pixelY;
    logic          trace;
    logic          InsideRectangle;
    logic [10:0]   offsetX;
    logic [10:0]   offsetY;
    logic [CW-1:0] traceCount;

    modport master (
        output startOfFrame, flying, clearTraces, birdX, birdY, pixelX, pixelY,
        input  trace, InsideRectangle, offsetX, offsetY, traceCount
    );

    modport slave (
        input  startOfFrame, flying, clearTraces, birdX, birdY, pixelX, pixelY,
        output trace, InsideRectangle, offsetX, offsetY, traceCount
    );
endinterface

// File: rtl/trace_recorder.sv
// Ring of sampled bird positions plus a one-stage raster hit test against the stored sprites.
// state  | meaning
// IDLE   | no traces, waiting for a flying rise
// RECORD | bird airborne, sampling every SAMPLE_PERIOD frames into the ring
// HOLD   | bird landed, traces frozen but still displayed
module trace_recorder #(
    parameter int NUM_TRACES    = 8,
    parameter int SAMPLE_PERIOD = 4,
    parameter int TRACE_SIZE    = 32
) (
    input  logic              clk,
    input  logic              resetN,
    trace_recorder_if.slave   bus
);
    localparam int PW = $clog2(NUM_TRACES);
    localparam int CW = PW + 1;
    localparam int FW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RECORD, ST_HOLD} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          r_flyingPrev;
    logic [10:0]   r_entX [NUM_TRACES];
    logic [10:0]   r_entY [NUM_TRACES];
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;
    logic [FW-1:0] r_frameCnt;
    logic          r_trace;
    logic [10:0]   r_offX;
    logic [10:0]   r_offY;

    logic          w_flyRise;
    logic          w_clear;
    logic          w_startShot;
    logic          w_advFrame;
    logic          w_doSample;

    logic [NUM_TRACES-1:0] w_inBox;
    logic [PW-1:0]         w_slot [NUM_TRACES];
    logic                  w_hit;
    logic [10:0]           w_offX;
    logic [10:0]           w_offY;

    assign w_flyRise = bus.flying & ~r_flyingPrev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= ST_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.clearTraces) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_flyRise)   w_nextState = ST_RECORD;
                ST_RECORD: if (!bus.flying) w_nextState = ST_HOLD;
                ST_HOLD:   if (w_flyRise)   w_nextState = ST_RECORD;
                default:                    w_nextState = ST_IDLE;
            endcase
        end
    end

    // A flying rise in RECORD is impossible (flying was already high), so it only starts shots from IDLE/HOLD.
    always_comb begin
        w_clear     = bus.clearTraces;
        w_startShot = 1'b0;
        w_advFrame  = 1'b0;
        w_doSample  = 1'b0;
        if (!bus.clearTraces) begin
            w_startShot = w_flyRise && (r_state != ST_RECORD);
            w_advFrame  = (r_state == ST_RECORD) && bus.startOfFrame && bus.flying;
            w_doSample  = w_advFrame && (r_frameCnt == '0);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_flyingPrev <= 1'b0;
            r_wrPtr      <= '0;
            r_count      <= '0;
            r_frameCnt   <= '0;
            for (int i = 0; i < NUM_TRACES; i++) begin
                r_entX[i] <= '0;
                r_entY[i] <= '0;
            end
        end else begin
            r_flyingPrev <= bus.flying;
            if (w_clear || w_startShot) begin
                r_wrPtr    <= '0;
                r_count    <= '0;
                r_frameCnt <= '0;
            end else if (w_advFrame) begin
                r_frameCnt <= (r_frameCnt == FW'(SAMPLE_PERIOD - 1)) ? '0 : r_frameCnt + 1'b1;
                if (w_doSample) begin
                    r_entX[r_wrPtr] <= bus.birdX;
                    r_entY[r_wrPtr] <= bus.birdY;
                    r_wrPtr         <= r_wrPtr + 1'b1;
                    if (r_count != CW'(NUM_TRACES)) r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // 12-bit compares keep sprites near x/y = 2047 from wrapping onto pixel 0.
    always_comb begin
        for (int i = 0; i < NUM_TRACES; i++) begin
            w_inBox[i] = ({1'b0, bus.pixelX} >= {1'b0, r_entX[i]}) &&
                         ({1'b0, bus.pixelX} <  ({1'b0, r_entX[i]} + 12'(TRACE_SIZE))) &&
                         ({1'b0, bus.pixelY} >= {1'b0, r_entY[i]}) &&
                         ({1'b0, bus.pixelY} <  ({1'b0, r_entY[i]} + 12'(TRACE_SIZE)));
        end
    end

    // w_slot[k] is the k-th most recent entry; scanning oldest to newest lets the newest hit win.
    always_comb begin
        for (int k = 0; k < NUM_TRACES; k++) begin
            w_slot[k] = r_wrPtr - PW'(k + 1);
        end
    end

    always_comb begin
        w_hit  = 1'b0;
        w_offX = '0;
        w_offY = '0;
        for (int k = NUM_TRACES - 1; k >= 0; k--) begin
            if ((CW'(k) < r_count) && w_inBox[w_slot[k]]) begin
                w_hit  = 1'b1;
                w_offX = bus.pixelX - r_entX[w_slot[k]];
                w_offY = bus.pixelY - r_entY[w_slot[k]];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_trace <= 1'b0;
            r_offX  <= '0;
            r_offY  <= '0;
        end else begin
            r_trace <= w_hit;
            r_offX  <= w_offX;
            r_offY  <= w_offY;
        end
    end

    assign bus.trace           = r_trace;
    assign bus.InsideRectangle = r_trace;
    assign bus.offsetX         = r_offX;
    assign bus.offsetY         = r_offY;
    assign bus.traceCount      = r_count;
endmodule

// File: tb/tb_trace_recorder.sv
// Directed bench: one recorder sampling every 4th frame, one sampling every frame.
module tb_trace_recorder;
    logic clk;
    logic resetN;
    int   n_checks;
    int   n_pass;

    trace_recorder_if #(.NUM_TRACES(8)) bus_a ();
    trace_recorder_if #(.NUM_TRACES(8)) bus_b ();

    trace_recorder #(.NUM_TRACES(8), .SAMPLE_PERIOD(4), .TRACE_SIZE(32)) dut_a (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_a.slave)
    );

    trace_recorder #(.NUM_TRACES(8), .SAMPLE_PERIOD(1), .TRACE_SIZE(32)) dut_b (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pix_b(input int x, input int y);
        bus_b.pixelX = 11'(x);
        bus_b.pixelY = 11'(y);
        tick();
    endtask

    task automatic sample_b(input int x, input int y);
        bus_b.birdX        = 11'(x);
        bus_b.birdY        = 11'(y);
        bus_b.startOfFrame = 1'b1;
        tick();
        bus_b.startOfFrame = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        resetN   = 1'b0;
        {bus_a.startOfFrame, bus_a.flying, bus_a.clearTraces} = 3'b000;
        {bus_a.birdX, bus_a.birdY, bus_a.pixelX, bus_a.pixelY} = '0;
        {bus_b.startOfFrame, bus_b.flying, bus_b.clearTraces} = 3'b000;
        {bus_b.birdX, bus_b.birdY, bus_b.pixelX, bus_b.pixelY} = '0;
        #12;
        check("rst_trace",  32'(bus_a.trace), 0);
        check("rst_inside", 32'(bus_a.InsideRectangle), 0);
        check("rst_offx",   32'(bus_a.offsetX), 0);
        check("rst_offy",   32'(bus_a.offsetY), 0);
        check("rst_count",  32'(bus_a.traceCount), 0);
        #10 resetN = 1'b1;
        tick();

        // Sampling every 4th frame: pulses k=0,4,8 land at x=100,140,180
        bus_a.flying = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            bus_a.birdX        = 11'(100 + 10 * k);
            bus_a.birdY        = 11'd200;
            bus_a.startOfFrame = 1'b1;
            tick();
            bus_a.startOfFrame = 1'b0;
            tick();
        end
        check("a_count3", 32'(bus_a.traceCount), 3);
        bus_a.pixelX = 11'd105; bus_a.pixelY = 11'd203; tick();
        check("a_e0_hit",  32'(bus_a.trace), 1);
        check("a_e0_offx", 32'(bus_a.offsetX), 5);
        check("a_e0_offy", 32'(bus_a.offsetY), 3);
        bus_a.pixelX = 11'd150; bus_a.pixelY = 11'd210; tick();
        check("a_e1_offx", 32'(bus_a.offsetX), 10);
        check("a_e1_offy", 32'(bus_a.offsetY), 10);
        bus_a.pixelX = 11'd185; bus_a.pixelY = 11'd200; tick();
        check("a_e2_offx", 32'(bus_a.offsetX), 5);
        bus_a.pixelX = 11'd135; tick();
        check("a_gap135", 32'(bus_a.trace), 0);
        bus_a.pixelX = 11'd175; tick();
        check("a_gap175", 32'(bus_a.trace), 0);

        // Ring overwrite with a sample every frame
        bus_b.flying = 1'b1;
        tick();
        for (int s = 0; s < 10; s++) sample_b(100 + 40 * s, 500);
        check("b_count_sat", 32'(bus_b.traceCount), 8);
        pix_b(100, 500);
        check("b_s0_gone", 32'(bus_b.trace), 0);
        pix_b(140, 500);
        check("b_s1_gone", 32'(bus_b.trace), 0);
        pix_b(180, 500);
        check("b_s2_hit", 32'(bus_b.trace), 1);
        pix_b(423, 502);
        check("b_s8_offx", 32'(bus_b.offsetX), 3);
        check("b_s8_offy", 32'(bus_b.offsetY), 2);
        bus_b.flying = 1'b0;
        pix_b(463, 504);
        check("b_s9_offx", 32'(bus_b.offsetX), 3);
        check("b_s9_offy", 32'(bus_b.offsetY), 4);
        check("b_hold_count", 32'(bus_b.traceCount), 8);
        bus_b.clearTraces = 1'b1;
        tick();
        bus_b.clearTraces = 1'b0;
        check("b_clear_count", 32'(bus_b.traceCount), 0);
        tick();
        check("b_clear_nohit", 32'(bus_b.trace), 0);

        // Single entry hit and edges
        bus_b.flying = 1'b1;
        tick();
        sample_b(300, 150);
        pix_b(315, 160);
        check("hit_trace",  32'(bus_b.trace), 1);
        check("hit_inside", 32'(bus_b.InsideRectangle), 1);
        check("hit_offx",   32'(bus_b.offsetX), 15);
        check("hit_offy",   32'(bus_b.offsetY), 10);
        pix_b(332, 160);
        check("right_edge_trace", 32'(bus_b.trace), 0);
        check("right_edge_offx",  32'(bus_b.offsetX), 0);
        check("right_edge_offy",  32'(bus_b.offsetY), 0);
        pix_b(299, 160);
        check("left_edge_trace", 32'(bus_b.trace), 0);

        // Overlap: newest entry wins
        sample_b(310, 150);
        pix_b(320, 155);
        check("ovl_offx", 32'(bus_b.offsetX), 10);
        check("ovl_offy", 32'(bus_b.offsetY), 5);
        pix_b(305, 155);
        check("ovl_old_offx", 32'(bus_b.offsetX), 5);

        // Right screen edge, no wrap to x=0
        sample_b(2040, 100);
        pix_b(2047, 105);
        check("edge_hit",  32'(bus_b.trace), 1);
        check("edge_offx", 32'(bus_b.offsetX), 7);
        check("edge_offy", 32'(bus_b.offsetY), 5);
        pix_b(0, 105);
        check("edge_nowrap", 32'(bus_b.trace), 0);

        // Clear beats a flying rise in HOLD
        bus_b.flying = 1'b0;
        tick();
        check("hold_count3", 32'(bus_b.traceCount), 3);
        bus_b.clearTraces = 1'b1;
        bus_b.flying      = 1'b1;
        tick();
        bus_b.clearTraces = 1'b0;
        check("clr_rise_count", 32'(bus_b.traceCount), 0);
        bus_b.startOfFrame = 1'b1;
        bus_b.birdX = 11'd650; bus_b.birdY = 11'd650;
        tick();
        bus_b.startOfFrame = 1'b0;
        check("clr_idle_nosample", 32'(bus_b.traceCount), 0);

        // Rise coinciding with startOfFrame only enters RECORD
        bus_b.flying = 1'b0;
        tick();
        bus_b.flying = 1'b1;
        sample_b(700, 700);
        check("rise_sof_nosample", 32'(bus_b.traceCount), 0);
        sample_b(600, 600);
        check("new_shot_count", 32'(bus_b.traceCount), 1);
        pix_b(610, 620);
        check("new_shot_offx", 32'(bus_b.offsetX), 10);
        check("new_shot_offy", 32'(bus_b.offsetY), 20);
        pix_b(705, 705);
        check("rise_sof_nohit", 32'(bus_b.trace), 0);

        // Asynchronous reset mid-RECORD
        pix_b(610, 620);
        #2 resetN = 1'b0;
        #1;
        check("async_rst_count", 32'(bus_b.traceCount), 0);
        check("async_rst_trace", 32'(bus_b.trace), 0);
        check("async_rst_count_a", 32'(bus_a.traceCount), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
